// File: rtl/param_ram.sv
// param_ram: single-port byte-enabled RAM behind a valid/ready request port, READ_LAT-deep response pipeline.
// Optional macro RAM_INIT_CLEAR_EN: sweep every word to zero after reset before accepting requests.
module param_ram #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          READ_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]       offset;
  logic [31:0]       word_idx;
  logic [AW-1:0]     acc_idx;
  logic              addr_err;
  logic              accept;
  logic              run;

  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_be;

  // The mask test is written without a slice so DATA_W = 8 (no offset bits) still elaborates.
  assign offset   = req_addr - BASE_ADDR;
  assign word_idx = offset >> OFF_W;
  assign acc_idx  = word_idx[AW-1:0];
  assign addr_err = (req_addr < BASE_ADDR) ||
                    (word_idx >= 32'(DEPTH)) ||
                    ((req_addr & 32'(BYTES - 1)) != 32'd0);

  assign req_ready = run && !rst;
  assign accept    = req_valid && req_ready;

`ifdef RAM_INIT_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
      if (clr_idx == AW'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  assign run = (state == ST_RUN);

  // The sweep shares the single write port so the array still maps onto one RAM.
  always_comb begin
    mem_we    = accept && req_we && !addr_err;
    mem_addr  = acc_idx;
    mem_wdata = req_wdata;
    mem_be    = req_be;
    if (!run && !rst) begin
      mem_we    = 1'b1;
      mem_addr  = clr_idx;
      mem_wdata = '0;
      mem_be    = '1;
    end
  end
`else
  assign run = 1'b1;

  always_comb begin
    mem_we    = accept && req_we && !addr_err;
    mem_addr  = acc_idx;
    mem_wdata = req_wdata;
    mem_be    = req_be;
  end
`endif

  logic [DATA_W-1:0] rdata_p [READ_LAT];
  logic              err_p   [READ_LAT];
  logic              rd_ok_p [READ_LAT];
  logic              vld_p   [READ_LAT];

  // Stage p0: array access at the acceptance edge; later stages only delay.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    rdata_p[0] <= mem[acc_idx];
    err_p[0]   <= addr_err;
    rd_ok_p[0] <= !req_we && !addr_err;
    for (int s = 1; s < READ_LAT; s++) begin
      rdata_p[s] <= rdata_p[s-1];
      err_p[s]   <= err_p[s-1];
      rd_ok_p[s] <= rd_ok_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < READ_LAT; s++) begin
        vld_p[s] <= 1'b0;
      end
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < READ_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  // Output stage: data is held at zero unless a good read is being returned.
  assign resp_valid = vld_p[READ_LAT-1] && !rst;
  assign resp_err   = resp_valid && err_p[READ_LAT-1];
  assign resp_rdata = (resp_valid && rd_ok_p[READ_LAT-1]) ? rdata_p[READ_LAT-1] : '0;

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: a default instance (READ_LAT=1) and a small READ_LAT=3 instance.
`timescale 1ns/1ps
module tb_param_ram;
  localparam int DEPTH_A = 1024;
  localparam int DEPTH_B = 16;
  localparam int LAT_A   = 1;
  localparam int LAT_B   = 3;
`ifdef RAM_INIT_CLEAR_EN
  localparam int CLR_EXP = DEPTH_B;
`else
  localparam int CLR_EXP = 0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_valid, a_ready, a_we, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_rst, b_valid, b_ready, b_we, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  param_ram u_dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
  );

  param_ram #(.DATA_W(32), .DEPTH(DEPTH_B), .BASE_ADDR(32'h0), .READ_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][DEPTH_A];
  int          resp_cnt [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Checks this cycle's response of one DUT, then records the request it is about to accept.
  task automatic mon(input int d, input logic rstv, input logic rv, input logic rerr,
                     input logic [31:0] rd, input logic acc, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [31:0] idx;
    int          dep;
    int          lat;
    if (rstv) begin
      if (d == 0) q0.delete(); else q1.delete();
      chk("rst_outputs", 64'({rv, rerr, rd}), 64'd0);
`ifdef RAM_INIT_CLEAR_EN
      for (int i = 0; i < DEPTH_A; i++) model[d][i] = '0;
`endif
      return;
    end
    if (rv) begin
      resp_cnt[d]++;
      if (qsize(d) == 0) begin
        chk($sformatf("unexpected_resp_dut%0d", d), 64'd1, 64'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        chk("resp_rdata", 64'(rd), 64'(e.rdata));
        chk("resp_err", 64'(rerr), 64'(e.err));
      end
    end else begin
      chk("idle_outputs", 64'({rerr, rd}), 64'd0);
      if (qsize(d) != 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (e.due <= cyc) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          chk($sformatf("missing_resp_dut%0d", d), 64'd0, 64'd1);
        end
      end
    end
    if (acc) begin
      dep     = (d == 0) ? DEPTH_A : DEPTH_B;
      lat     = (d == 0) ? LAT_A : LAT_B;
      idx     = addr >> 2;
      e.err   = (addr[1:0] != 2'b00) || (idx >= 32'(dep));
      e.rdata = (!we && !e.err) ? model[d][idx[9:0]] : 32'd0;
      e.due   = cyc + lat;
      if (we && !e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[d][idx[9:0]][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_rst, a_rvalid, a_err, a_rdata, a_valid && a_ready, a_we, a_addr, a_wdata, a_be);
    mon(1, b_rst, b_rvalid, b_err, b_rdata, b_valid && b_ready, b_we, b_addr, b_wdata, b_be);
  end

  // Called just after a rising edge; returns just after the edge that accepts the request.
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    if (d == 0) begin
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    end else begin
      b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    end
    @(negedge clk);
    while (!((d == 0) ? a_ready : b_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cnt_at_rst;
    logic [31:0] ad;
    resp_cnt[0] = 0; resp_cnt[1] = 0;
    a_rst = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(a_ready), 64'(CLR_EXP == 0));
    @(posedge clk);
    #1;

    // Write then read on the very next cycle.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    // Partial write through byte enables.
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
    // Out-of-range and misaligned requests; word 0 must survive them.
    issue(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    issue(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    issue(0, 1'b0, 32'h2, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h2, 32'h12345678, 4'hF);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
    issue(0, 1'b0, 32'hFFC, 32'h0, 4'h0);
    idle(0);
    drain();

    // Random mixed traffic over a small window of initialised words.
    for (int i = 0; i < 32; i++) issue(0, 1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      ad = 32'($urandom_range(0, 31) * 4);
      issue(0, 1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(0);
    drain();

    // Deep pipeline: fill words, then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) issue(1, 1'b1, 32'(i * 4), 32'hB0B0_0000 + 32'(i * 32'h111), 4'hF);
    for (int i = 0; i < 8; i++) issue(1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
    idle(1);
    drain();

    // Reset in the middle of a read burst: in-flight responses are dropped.
    for (int i = 0; i < 5; i++) issue(1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle(1);
    b_rst = 1'b1;
    cnt_at_rst = resp_cnt[1];
    repeat (3) @(posedge clk);
    #1;
    b_rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_rise_cycles", 64'(n), 64'(CLR_EXP));
    repeat (8) @(negedge clk);
    chk("no_resp_after_rst", 64'(resp_cnt[1] - cnt_at_rst), 64'd0);
    @(posedge clk);
    #1;

    // Contents after reset: retained, or zero when the clear sweep is built in.
    issue(1, 1'b0, 32'h0, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h1C, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h3C, 32'h0, 4'h0);
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
